// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes, command codes, frame state and key map shared by the PS/2 decoder
package ps2_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;
  localparam logic [7:0] SC_E0 = 8'hE0, SC_F0 = 8'hF0;
  localparam logic [7:0] SC_NUM0 = 8'h45, SC_NUM1 = 8'h16, SC_NUM2 = 8'h1E, SC_NUM3 = 8'h26;
  localparam logic [7:0] SC_RED = 8'h2D, SC_GREEN = 8'h34, SC_BLUE = 8'h32;
  localparam logic [7:0] SC_PLUS = 8'h79, SC_MINUS = 8'h7B, SC_K = 8'h42, SC_FLASH = 8'h2B;
  localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;
  localparam logic [3:0] CMD_NUM0 = 4'h0, CMD_NUM1 = 4'h1, CMD_NUM2 = 4'h2, CMD_NUM3 = 4'h3;
  localparam logic [3:0] CMD_RED = 4'h4, CMD_GREEN = 4'h5, CMD_BLUE = 4'h6;
  localparam logic [3:0] CMD_UP = 4'h7, CMD_DOWN = 4'h8, CMD_LEFT = 4'h9, CMD_RIGHT = 4'hA;
  localparam logic [3:0] CMD_PLUS = 4'hB, CMD_MINUS = 4'hC, CMD_K = 4'hD, CMD_FLASH = 4'hE;
  localparam logic [3:0] CMD_IDLE = 4'hF;
  function automatic logic [3:0] key_map(input logic ext, input logic [7:0] sc);
    key_map = CMD_IDLE;
    if (ext)
      case (sc)
        SC_UP:    key_map = CMD_UP;
        SC_DOWN:  key_map = CMD_DOWN;
        SC_LEFT:  key_map = CMD_LEFT;
        SC_RIGHT: key_map = CMD_RIGHT;
        default:  key_map = CMD_IDLE;
      endcase
    else
      case (sc)
        SC_NUM0:  key_map = CMD_NUM0;
        SC_NUM1:  key_map = CMD_NUM1;
        SC_NUM2:  key_map = CMD_NUM2;
        SC_NUM3:  key_map = CMD_NUM3;
        SC_RED:   key_map = CMD_RED;
        SC_GREEN: key_map = CMD_GREEN;
        SC_BLUE:  key_map = CMD_BLUE;
        SC_PLUS:  key_map = CMD_PLUS;
        SC_MINUS: key_map = CMD_MINUS;
        SC_K:     key_map = CMD_K;
        SC_FLASH: key_map = CMD_FLASH;
        default:  key_map = CMD_IDLE;
      endcase
  endfunction
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises and filters the PS/2 lines and deserialises 11-bit frames
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] dataByte,
  output logic       byteRdy,
  output logic       frameErr
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic [FW-1:0] fcnt;
  logic filt, filt_d, fall, dat_s;
  frame_state_t state, state_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shreg, sh_n;
  logic par, par_n, rdy_n, err_n;
  logic [TW-1:0] tcnt, tcnt_n;
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall = filt_d & ~filt;
  assign dataByte = shreg;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      fcnt <= '0;
      filt <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2Clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2Data};
      filt_d <= filt;
      // a level change is taken only after FILTER_LEN consecutive differing samples
      fcnt <= (clk_sync[SYNC_STAGES-1] != filt && fcnt != FMAX) ? fcnt + 1'b1 : '0;
      if (clk_sync[SYNC_STAGES-1] != filt && fcnt == FMAX) filt <= clk_sync[SYNC_STAGES-1];
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      tcnt <= '0;
      byteRdy <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      shreg <= sh_n;
      par <= par_n;
      tcnt <= tcnt_n;
      byteRdy <= rdy_n;
      frameErr <= err_n;
    end
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    sh_n = shreg;
    par_n = par;
    tcnt_n = '0;
    rdy_n = 1'b0;
    err_n = 1'b0;
    if (state != ST_IDLE) tcnt_n = fall ? '0 : tcnt + 1'b1;
    if (fall)
      case (state)
        ST_IDLE: if (!dat_s) begin
          state_n = ST_DATA;
          bit_n = '0;
        end
        ST_DATA: begin
          sh_n = {dat_s, shreg[7:1]};
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_n = dat_s;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          rdy_n = dat_s & (^{shreg, par});
          err_n = ~rdy_n;
        end
        default: state_n = ST_IDLE;
      endcase
    else if (state != ST_IDLE && tcnt == TMAX) begin
      state_n = ST_IDLE;
      err_n = 1'b1;
      tcnt_n = '0;
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: tracks E0/F0 prefixes on received bytes and maps key presses to command codes
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [3:0] inCode,
  output logic       codeValid,
  output logic       frameErr
);
  logic [7:0] rx_byte;
  logic rx_rdy, ext, brk;
  ps2_rx_frame #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock(clock),
    .reset(reset),
    .ps2Clk(ps2Clk),
    .ps2Data(ps2Data),
    .dataByte(rx_byte),
    .byteRdy(rx_rdy),
    .frameErr(frameErr)
  );
  assign codeValid = inCode != CMD_IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ext <= 1'b0;
      brk <= 1'b0;
      inCode <= CMD_IDLE;
    end else begin
      inCode <= CMD_IDLE;
      if (frameErr) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_rdy) begin
        if (rx_byte == SC_E0) ext <= 1'b1;
        else if (rx_byte == SC_F0) brk <= 1'b1;
        else begin
          inCode <= brk ? CMD_IDLE : key_map(ext, rx_byte);
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage of the input decoder. Receives raw PS/2 keyboard clock/data, deserializes 11-bit frames and tracks E0/F0 prefixes.
- Maps selected make codes to the 4-bit command code bus. Each recognised key press drives its code for exactly one clock cycle; otherwise the bus holds the idle code 4'hF.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ps2Clk and ps2Data before use.
- FILTER_LEN, 4, cycles ps2Clk must be stable before a level change is accepted.
- TIMEOUT_CYCLES, 50000, idle cycles inside a frame before it is aborted (1 ms at 50 MHz).

Ports:
- clock, in, 1, system clock; all state on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- ps2Clk, in, 1, raw PS/2 clock from the keyboard (asynchronous).
- ps2Data, in, 1, raw PS/2 data from the keyboard (asynchronous).
- inCode, out, 4, command code; valid value for one cycle per key press, else 4'hF.
- codeValid, out, 1, high in exactly the cycles where inCode != 4'hF.
- frameErr, out, 1, one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset (reset=0, asynchronous):
  - inCode=4'hF, codeValid=0, frameErr=0.
  - Frame FSM returns to IDLE; bit count, shift register, extPending, breakPending and timeout counter are cleared; sync/filter registers are set to 1.
  - Reset mid-frame discards the partial frame and produces no outputs.
- Input conditioning:
  - Both lines pass through SYNC_STAGES flops.
  - ps2Clk additionally passes the FILTER_LEN stability filter.
  - A falling edge of the filtered clock is a one-cycle "fall" strobe. ps2Data (synchronised) is sampled on fall.
- Frame FSM:
  - IDLE: on fall with data=0 (start bit), go to DATA with bitCnt=0. On fall with data=1, stay in IDLE; this is not an error.
  - DATA: each fall shifts the data bit in LSB-first and increments bitCnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, the frame is good if stop=1 and the XOR of the 8 data bits and the parity bit equals 1 (odd parity). Go to IDLE.
  - A good frame raises byteRdy for one cycle. A bad frame raises frameErr for one cycle (the cycle after the fall) and clears extPending and breakPending.
- Timeout:
  - Outside IDLE, the counter increments every cycle without a fall and resets on each fall.
  - On reaching TIMEOUT_CYCLES: return to IDLE, pulse frameErr once, clear the prefix flags.
- Byte handling on byteRdy:
  - 8'hE0: set extPending; no output.
  - 8'hF0: set breakPending; no output.
  - Any other byte: if breakPending, suppress output; else look the byte up in the map using extPending. Then clear both flags.
  - Unmapped bytes emit nothing and are not errors.
- Key map (make code -> inCode), non-extended:
  - 45->0, 16->1, 1E->2, 26->3
  - 2D(R)->4, 34(G)->5, 32(B)->6
  - 79(kp+)->B, 7B(kp-)->C
  - 42(K)->D, 2B(F)->E
- Key map, extended (E0 prefix):
  - 75->7, 72->8, 6B->9, 74->A
- Prefix rules:
  - The same byte with the wrong extPending state is unmapped. For example, non-extended 75 (kp8) emits nothing; E0 45 emits nothing.
  - Sequence E0 F0 xx is an extended break and is suppressed.
- Latency: inCode/codeValid are registered and appear in the cycle after byteRdy, i.e. 2 cycles after the stop-bit fall strobe. They return to 4'hF/0 on the following cycle.
- Typematic repeats (repeated make codes without a break) each produce a new pulse.
- Frames arrive far slower than the output pulse lasts, so no queuing is needed. A new byteRdy always overrides.

Decomposition:
- Shared package (ps2_pkg):
  - Scan-code constants: SC_E0, SC_F0, and each mapped key.
  - Command-code constants: CMD_NUM0..CMD_FLASH, CMD_IDLE=4'hF.
  - Frame FSM state enum.
- One sub-module, ps2_rx_frame:
  - Contains sync, filter, frame FSM and timeout.
  - Outputs byte[7:0], byteRdy and frameErr.
- Top level: prefix flags and key map.

Test Plan:
- Reset: release reset with lines idle high -> inCode=4'hF, codeValid=0, frameErr=0 for 1000 cycles.
- Frame 8'h16, valid odd parity -> one pulse inCode=4'h1, codeValid=1, 2 cycles after the stop fall. Then send F0 16 -> no pulse.
- Send E0 75 -> inCode=4'h7 once. Send 75 alone -> no pulse. Send E0 F0 75 -> no pulse.
- Frame 8'h2D with flipped parity -> frameErr pulse, no code. A following E0 whose data frame is corrupted, then 75 -> no pulse (prefix cleared).
- Stop after 4 data bits and wait TIMEOUT_CYCLES -> one frameErr pulse. Then a good 8'h2B frame -> inCode=4'hE.
- Assert reset low mid-DATA of 8'h45, release, send 8'h45 -> exactly one pulse inCode=4'h0. Also check a 2-cycle ps2Clk glitch is ignored.
